// File: rtl/uart_rx_param_if.sv
// Consumer-side bundle of the UART receiver: FIFO drain port and sticky error status.
// The receiver drives the slave modport, the consumer the master modport.
interface uart_rx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 rdreq;
  logic [DATA_BITS-1:0] rdata;
  logic                 rdempty;
  logic [CNT_W-1:0]     rdusedw;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 err_clr;

  modport master (
    output rdreq, err_clr,
    input  rdata, rdempty, rdusedw, frame_err, parity_err, overrun
  );

  modport slave (
    input  rdreq, err_clr,
    output rdata, rdempty, rdusedw, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised 16x-oversampling UART receiver with majority-vote sampling,
// configurable frame format, sticky error flags and a non-show-ahead receive FIFO.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_rxd,
  uart_rx_param_if.slave  bus
);
  localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic pbit);
    logic sum;
    sum = (^data) ^ pbit;
    if (PARITY == 1) begin
      parity_ok = sum;
    end else begin
      parity_ok = ~sum;
    end
  endfunction

  logic                 rxd_meta_r, rxd_sync_r, armed_r;
  logic [2:0]           state_r;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [3:0]           tick_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic                 stop_cnt_r;
  logic                 vote7_r, vote8_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 parity_bad_r, frame_bad_r;
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 rdempty_r;
  logic [DATA_BITS-1:0] rdata_r;
  logic                 frame_err_r, parity_err_r, overrun_r;

  logic tick_s, at9_s, at15_s, sample_s, done_s, frame_bad_s, push_s, rd_ok_s, wr_ok_s;

  assign tick_s      = (state_r != ST_IDLE) && (div_cnt_r == DIV_W'(DIV - 1));
  assign at9_s       = tick_s && (tick_cnt_r == 4'd9);
  assign at15_s      = tick_s && (tick_cnt_r == 4'd15);
  assign sample_s    = majority3(vote7_r, vote8_r, rxd_sync_r);
  // The frame ends at the centre of the last stop bit, so its own sample is folded in here.
  assign done_s      = (state_r == ST_STOP) && at9_s && (stop_cnt_r == 1'(STOP_BITS - 1));
  assign frame_bad_s = frame_bad_r | ~sample_s;
  assign push_s      = done_s && !frame_bad_s && !parity_bad_r;
  assign rd_ok_s     = bus.rdreq && !rdempty_r;
  assign wr_ok_s     = push_s && ((count_r != CNT_W'(FIFO_DEPTH)) || rd_ok_s);

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= uart_rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  // Receive FSM: start detection, oversampling tick timing, majority sampling, frame checks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      armed_r      <= 1'b0;
      div_cnt_r    <= '0;
      tick_cnt_r   <= 4'd0;
      bit_cnt_r    <= '0;
      stop_cnt_r   <= 1'b0;
      vote7_r      <= 1'b1;
      vote8_r      <= 1'b1;
      shift_r      <= '0;
      parity_bad_r <= 1'b0;
      frame_bad_r  <= 1'b0;
    end else begin
      if (state_r == ST_IDLE) begin
        div_cnt_r  <= '0;
        tick_cnt_r <= 4'd0;
      end else if (tick_s) begin
        div_cnt_r  <= '0;
        tick_cnt_r <= tick_cnt_r + 4'd1;
      end else begin
        div_cnt_r  <= div_cnt_r + DIV_W'(1);
      end
      if (tick_s && (tick_cnt_r == 4'd7)) vote7_r <= rxd_sync_r;
      if (tick_s && (tick_cnt_r == 4'd8)) vote8_r <= rxd_sync_r;

      case (state_r)
        ST_IDLE: begin
          // armed_r stays low after a frame error until the line is seen high again
          if (rxd_sync_r) begin
            armed_r <= 1'b1;
          end else if (armed_r) begin
            armed_r      <= 1'b0;
            state_r      <= ST_START;
            frame_bad_r  <= 1'b0;
            parity_bad_r <= 1'b0;
          end
        end
        ST_START: begin
          if (at9_s && sample_s) begin
            state_r <= ST_IDLE;
          end else if (at15_s) begin
            state_r   <= ST_DATA;
            bit_cnt_r <= '0;
          end
        end
        ST_DATA: begin
          if (at9_s) shift_r <= {sample_s, shift_r[DATA_BITS-1:1]};
          if (at15_s) begin
            if (bit_cnt_r == BIT_W'(DATA_BITS - 1)) begin
              state_r    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              stop_cnt_r <= 1'b0;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (at9_s) parity_bad_r <= ~parity_ok(shift_r, sample_s);
          if (at15_s) begin
            state_r    <= ST_STOP;
            stop_cnt_r <= 1'b0;
          end
        end
        ST_STOP: begin
          if (done_s) begin
            state_r <= ST_IDLE;
          end else begin
            if (at9_s && !sample_s) frame_bad_r <= 1'b1;
            if (at15_s) stop_cnt_r <= stop_cnt_r + 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Storage array; occupancy gates every read, so the contents need no reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_r[wr_ptr_r] <= shift_r;
  end

  // FIFO pointers, occupancy and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      rdempty_r <= 1'b1;
      rdata_r   <= '0;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        rdata_r  <= mem_r[rd_ptr_r];
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10: begin
          count_r   <= count_r + CNT_W'(1);
          rdempty_r <= 1'b0;
        end
        2'b01: begin
          count_r   <= count_r - CNT_W'(1);
          rdempty_r <= (count_r == CNT_W'(1));
        end
        default: begin
          count_r   <= count_r;
          rdempty_r <= rdempty_r;
        end
      endcase
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_err_r  <= (done_s && frame_bad_s) | (frame_err_r & ~bus.err_clr);
      parity_err_r <= (done_s && !frame_bad_s && parity_bad_r) | (parity_err_r & ~bus.err_clr);
      overrun_r    <= (push_s && !wr_ok_s) | (overrun_r & ~bus.err_clr);
    end
  end

  assign bus.rdata      = rdata_r;
  assign bus.rdempty    = rdempty_r;
  assign bus.rdusedw    = count_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.parity_err = parity_err_r;
  assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four differently configured receivers fed by a timed
// bit-level transmitter and checked against a list-based model of stored bytes and flags.
`timescale 1ns/1ps
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] rxd, rdreq_v, clr_v, empty_v, ferr_v, perr_v, ovr_v;
  logic [3:0][8:0] rdata_v;
  logic [3:0][4:0] used_v;

  // per-receiver frame format; bit time = DIV * 16 clock periods of 10 ns
  int bits_c  [4] = '{8, 8, 8, 7};
  int par_c   [4] = '{0, 2, 0, 1};
  int stop_c  [4] = '{1, 1, 1, 2};
  int depth_c [4] = '{16, 16, 4, 16};
  int bit_ns  [4] = '{640, 640, 640, 1600};

  int mq [4][16];
  int mcnt [4];
  int last_rd [4];
  bit m_ferr [4], m_perr [4], m_ovr [4];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();
  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if2 ();
  uart_rx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if3 ();

  uart_rx_param #(.CLK_FREQ(64_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16))
    u0 (.clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .bus(if0));
  uart_rx_param #(.CLK_FREQ(64_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(16))
    u1 (.clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .bus(if1));
  uart_rx_param #(.CLK_FREQ(64_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4))
    u2 (.clk(clk), .rst_n(rst_n), .uart_rxd(rxd[2]), .bus(if2));
  uart_rx_param #(.CLK_FREQ(18_432_000), .BAUD(115_200), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(16))
    u3 (.clk(clk), .rst_n(rst_n), .uart_rxd(rxd[3]), .bus(if3));

  assign {if0.rdreq, if0.err_clr} = {rdreq_v[0], clr_v[0]};
  assign {if1.rdreq, if1.err_clr} = {rdreq_v[1], clr_v[1]};
  assign {if2.rdreq, if2.err_clr} = {rdreq_v[2], clr_v[2]};
  assign {if3.rdreq, if3.err_clr} = {rdreq_v[3], clr_v[3]};
  assign rdata_v[0] = 9'(if0.rdata);
  assign rdata_v[1] = 9'(if1.rdata);
  assign rdata_v[2] = 9'(if2.rdata);
  assign rdata_v[3] = 9'(if3.rdata);
  assign used_v[0] = 5'(if0.rdusedw);
  assign used_v[1] = 5'(if1.rdusedw);
  assign used_v[2] = 5'(if2.rdusedw);
  assign used_v[3] = 5'(if3.rdusedw);
  assign {empty_v[0], ferr_v[0], perr_v[0], ovr_v[0]} = {if0.rdempty, if0.frame_err, if0.parity_err, if0.overrun};
  assign {empty_v[1], ferr_v[1], perr_v[1], ovr_v[1]} = {if1.rdempty, if1.frame_err, if1.parity_err, if1.overrun};
  assign {empty_v[2], ferr_v[2], perr_v[2], ovr_v[2]} = {if2.rdempty, if2.frame_err, if2.parity_err, if2.overrun};
  assign {empty_v[3], ferr_v[3], perr_v[3], ovr_v[3]} = {if3.rdempty, if3.frame_err, if3.parity_err, if3.overrun};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic void model_push(input int idx, input int data);
    if (mcnt[idx] < depth_c[idx]) begin
      mq[idx][mcnt[idx]] = data;
      mcnt[idx]++;
    end else begin
      m_ovr[idx] = 1'b1;
    end
  endfunction

  task automatic check_state(input int idx);
    check($sformatf("u%0d rdempty", idx), 32'(empty_v[idx]), 32'(mcnt[idx] == 0));
    check($sformatf("u%0d rdusedw", idx), 32'(used_v[idx]), 32'(mcnt[idx]));
    check($sformatf("u%0d frame_err", idx), 32'(ferr_v[idx]), 32'(m_ferr[idx]));
    check($sformatf("u%0d parity_err", idx), 32'(perr_v[idx]), 32'(m_perr[idx]));
    check($sformatf("u%0d overrun", idx), 32'(ovr_v[idx]), 32'(m_ovr[idx]));
  endtask

  task automatic clear_errs(input int idx);
    @(negedge clk);
    clr_v[idx] = 1'b1;
    @(negedge clk);
    clr_v[idx] = 1'b0;
    m_ferr[idx] = 1'b0;
    m_perr[idx] = 1'b0;
    m_ovr[idx]  = 1'b0;
  endtask

  // one pop; on an empty FIFO the request must change nothing
  task automatic pop_check(input int idx);
    int want;
    @(negedge clk);
    rdreq_v[idx] = 1'b1;
    @(negedge clk);
    rdreq_v[idx] = 1'b0;
    if (mcnt[idx] == 0) begin
      check($sformatf("u%0d empty-read rdusedw", idx), 32'(used_v[idx]), 32'd0);
      check($sformatf("u%0d empty-read rdata", idx), 32'(rdata_v[idx]), 32'(last_rd[idx]));
    end else begin
      want = mq[idx][0];
      for (int k = 1; k < mcnt[idx]; k++) mq[idx][k-1] = mq[idx][k];
      mcnt[idx]--;
      last_rd[idx] = want;
      check($sformatf("u%0d rdata", idx), 32'(rdata_v[idx]), 32'(want));
      check($sformatf("u%0d rdusedw after read", idx), 32'(used_v[idx]), 32'(mcnt[idx]));
    end
  endtask

  // transmit one frame at a scaled bit period, followed by one idle bit; update the model
  task automatic send_frame(input int idx, input int data, input real scale,
                            input bit bad_par, input bit bad_stop);
    real bt;
    int  ones;
    bit  pbit;
    bt   = real'(bit_ns[idx]) * scale;
    ones = 0;
    rxd[idx] = 1'b0;
    #(bt);
    for (int i = 0; i < bits_c[idx]; i++) begin
      rxd[idx] = data[i];
      ones += int'(data[i]);
      #(bt);
    end
    if (par_c[idx] != 0) begin
      pbit = (par_c[idx] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      rxd[idx] = pbit ^ bad_par;
      #(bt);
    end
    for (int s = 0; s < stop_c[idx]; s++) begin
      rxd[idx] = ~bad_stop;
      #(bt);
    end
    rxd[idx] = 1'b1;
    #(bt);
    if (bad_stop) m_ferr[idx] = 1'b1;
    else if ((par_c[idx] != 0) && bad_par) m_perr[idx] = 1'b1;
    else model_push(idx, data);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    int d, r, k, nf;
    real sc;
    rxd = '1;
    rdreq_v = '0;
    clr_v = '0;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_state(i);
      check($sformatf("u%0d reset rdata", i), 32'(rdata_v[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // reset in the middle of a frame discards it
    rxd[0] = 1'b0;
    #(640 * 4);
    @(negedge clk);
    rst_n = 1'b0;
    rxd[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #(640 * 3);
    @(negedge clk);
    check_state(0);

    // 0x55 8N1: rdempty falls during the stop bit, right after its centre
    pat = 8'h55;
    rxd[0] = 1'b0;
    #(640);
    for (int i = 0; i < 8; i++) begin
      rxd[0] = pat[i];
      #(640);
    end
    rxd[0] = 1'b1;
    #(256);
    check("u0 rdempty before stop centre", 32'(empty_v[0]), 32'd1);
    #(320);
    check("u0 rdempty after stop centre", 32'(empty_v[0]), 32'd0);
    model_push(0, 32'h55);
    #(704);
    @(negedge clk);
    check_state(0);
    pop_check(0);
    check_state(0);

    // even parity: good frame stored, flipped parity dropped and flagged
    send_frame(1, 32'hA3, 1.0, 1'b0, 1'b0);
    check_state(1);
    send_frame(1, 32'hA3, 1.0, 1'b1, 1'b0);
    check_state(1);
    clear_errs(1);
    check_state(1);
    pop_check(1);

    // short low glitch is a false start
    rxd[0] = 1'b0;
    #(50);
    rxd[0] = 1'b1;
    #(640 * 2);
    send_frame(0, 32'h3C, 1.0, 1'b0, 1'b0);
    check_state(0);
    pop_check(0);

    // 20-bit break: one frame error, cleared midway, never raised again while low
    rxd[0] = 1'b0;
    #(640 * 12);
    m_ferr[0] = 1'b1;
    @(negedge clk);
    check_state(0);
    clear_errs(0);
    #(640 * 8);
    @(negedge clk);
    check_state(0);
    rxd[0] = 1'b1;
    #(640);
    send_frame(0, 32'h81, 1.0, 1'b0, 1'b0);
    check_state(0);
    pop_check(0);

    // depth-4 FIFO overflow
    for (int v = 1; v <= 5; v++) send_frame(2, v, 1.0, 1'b0, 1'b0);
    check_state(2);
    for (int v = 0; v < 4; v++) pop_check(2);
    check_state(2);
    pop_check(2);
    clear_errs(2);
    check_state(2);

    // 7O2 at +/-2% transmitter rate error
    send_frame(3, 32'h5A, 1.02, 1'b0, 1'b0);
    send_frame(3, 32'h5A, 0.98, 1'b0, 1'b0);
    check_state(3);
    pop_check(3);
    pop_check(3);
    check_state(3);

    // randomised traffic with errors, rate skew, reads and clears
    for (int idx = 0; idx < 4; idx++) begin
      nf = (idx == 3) ? 6 : 14;
      for (int f = 0; f < nf; f++) begin
        d  = int'($urandom_range(0, (1 << bits_c[idx]) - 1));
        r  = int'($urandom_range(0, 99));
        k  = int'($urandom_range(0, 2));
        sc = (k == 0) ? 0.98 : ((k == 1) ? 1.0 : 1.02);
        send_frame(idx, d, sc, (par_c[idx] != 0) && (r < 15), r >= 88);
        check_state(idx);
        if ($urandom_range(0, 2) == 0) pop_check(idx);
        if ((m_ferr[idx] || m_perr[idx] || m_ovr[idx]) && ($urandom_range(0, 1) == 1)) begin
          clear_errs(idx);
          check_state(idx);
        end
      end
      while (mcnt[idx] > 0) pop_check(idx);
      check_state(idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
